// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - AES round-key buffer: capture from encryptor, reverse replay to decryptor
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, new key session (latches cipher_key, sbox_in)
//   cipher_key, sbox_in cipher key and dynamic S-box selector from the encryptor
//   wr_en/wr_idx/wr_key round-key write port from the encryptor
//   rd_start            begin reverse replay (only honoured when all slots are written)
//   rd_valid/rd_ready   replay handshake; rd_key/rd_idx/rd_last are the beat payload
//   sbox_out            latched S-box selector for the decryptor
//   keys_full           all round slots written in this session
//   wr_err              sticky illegal-write flag
//   dec_valid/dec_data/ref_data/data_match  registered plaintext compare
module round_key_store #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4,
    parameter int SBOX_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  cipher_key,
    input  logic [SBOX_W-1:0] sbox_in,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [KEY_W-1:0]  rd_key,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              rd_last,
    output logic [SBOX_W-1:0] sbox_out,
    output logic              keys_full,
    output logic              wr_err,
    input  logic              dec_valid,
    input  logic [KEY_W-1:0]  dec_data,
    input  logic [KEY_W-1:0]  ref_data,
    output logic              data_match
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Slot NUM_ROUNDS holds the cipher key; it is also the index of the final replay beat.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    logic [KEY_W-1:0]      slot_q [0:NUM_ROUNDS];

    logic [1:0]            state_q, state_d;
    logic [NUM_ROUNDS-1:0] valid_q, valid_d;
    logic                  keys_full_q, keys_full_d;
    logic                  wr_err_q, wr_err_d;
    logic                  data_match_q, data_match_d;
    logic [SBOX_W-1:0]     sbox_q, sbox_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [KEY_W-1:0]      rd_key_q, rd_key_d;

    logic                  start_acc;
    logic                  wr_legal;
    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      rd_slot;

    always_comb begin
        start_acc    = start && (state_q != ST_DRAIN);
        // A write coinciding with an accepted start is silently dropped, not flagged.
        wr_legal     = wr_en && !start_acc && (state_q == ST_FILL) && (wr_idx < LAST_IDX);

        state_d      = state_q;
        valid_d      = valid_q;
        keys_full_d  = keys_full_q;
        wr_err_d     = wr_err_q;
        data_match_d = data_match_q;
        sbox_d       = sbox_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        rd_idx_d     = rd_idx_q;
        rd_key_d     = rd_key_q;
        next_idx     = rd_idx_q + IDX_W'(1);
        rd_slot      = LAST_IDX - IDX_W'(1) - next_idx;

        if (start_acc) begin
            state_d      = ST_FILL;
            valid_d      = '0;
            keys_full_d  = 1'b0;
            wr_err_d     = 1'b0;
            data_match_d = 1'b0;
            sbox_d       = sbox_in;
        end else begin
            if (wr_en && !wr_legal) begin
                wr_err_d = 1'b1;
            end
            if (wr_legal) begin
                valid_d = valid_q | (NUM_ROUNDS'(1) << wr_idx);
                if (&valid_d) begin
                    state_d     = ST_READY;
                    keys_full_d = 1'b1;
                end
            end
            if (dec_valid) begin
                data_match_d = (dec_data == ref_data);
            end

            case (state_q)
                ST_READY: begin
                    if (rd_start) begin
                        state_d    = ST_DRAIN;
                        rd_valid_d = 1'b1;
                        rd_idx_d   = '0;
                        rd_last_d  = 1'b0;
                        rd_key_d   = slot_q[NUM_ROUNDS-1];
                    end
                end
                ST_DRAIN: begin
                    // The next beat's key is fetched at accept time so rd_key stays a flop output.
                    if (rd_ready) begin
                        if (rd_last_q) begin
                            state_d    = ST_READY;
                            rd_valid_d = 1'b0;
                            rd_last_d  = 1'b0;
                            rd_idx_d   = '0;
                            rd_key_d   = '0;
                        end else begin
                            rd_idx_d = next_idx;
                            if (next_idx == LAST_IDX) begin
                                rd_last_d = 1'b1;
                                rd_key_d  = slot_q[NUM_ROUNDS];
                            end else begin
                                rd_key_d  = slot_q[rd_slot];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Key storage is not reset; valid bits gate every read of it.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            slot_q[NUM_ROUNDS] <= cipher_key;
        end
        if (wr_legal) begin
            slot_q[wr_idx] <= wr_key;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            keys_full_q  <= 1'b0;
            wr_err_q     <= 1'b0;
            data_match_q <= 1'b0;
            sbox_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_idx_q     <= '0;
            rd_key_q     <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            keys_full_q  <= keys_full_d;
            wr_err_q     <= wr_err_d;
            data_match_q <= data_match_d;
            sbox_q       <= sbox_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            rd_idx_q     <= rd_idx_d;
            rd_key_q     <= rd_key_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_key     = rd_key_q;
    assign rd_idx     = rd_idx_q;
    assign rd_last    = rd_last_q;
    assign sbox_out   = sbox_q;
    assign keys_full  = keys_full_q;
    assign wr_err     = wr_err_q;
    assign data_match = data_match_q;

endmodule

// File: tb/tb_round_key_store.sv
// tb/tb_round_key_store.sv - self-checking bench for round_key_store
module tb_round_key_store;

    localparam int KW = 128;
    localparam int NR = 10;
    localparam int IW = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] cipher_key = '0;
    logic [SW-1:0] sbox_in = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [KW-1:0] wr_key = '0;
    logic          rd_start = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [KW-1:0] rd_key;
    logic [IW-1:0] rd_idx;
    logic          rd_last;
    logic [SW-1:0] sbox_out;
    logic          keys_full;
    logic          wr_err;
    logic          dec_valid = 1'b0;
    logic [KW-1:0] dec_data = '0;
    logic [KW-1:0] ref_data = '0;
    logic          data_match;

    int n_checks = 0;
    int n_errors = 0;

    logic [KW-1:0] ck = 128'h000102030405060708090a0b0c0d0e0f;
    logic [KW-1:0] dead = {4{32'hDEADBEEF}};

    always #5 clk = ~clk;

    round_key_store #(.KEY_W(KW), .NUM_ROUNDS(NR), .IDX_W(IW), .SBOX_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .cipher_key(cipher_key), .sbox_in(sbox_in),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_key(rd_key), .rd_idx(rd_idx), .rd_last(rd_last),
        .sbox_out(sbox_out), .keys_full(keys_full), .wr_err(wr_err), .dec_valid(dec_valid),
        .dec_data(dec_data), .ref_data(ref_data), .data_match(data_match)
    );

    // Reference model: a session holds NR round keys plus the cipher key; replay walks beats
    // 0..NR, beat b showing round key NR-1-b and the final beat showing the cipher key.
    logic [KW-1:0] m_slot [0:NR];
    bit            m_written [NR];
    bit            m_session, m_full, m_drain, m_err, m_match;
    int            m_beat;
    logic [SW-1:0] m_sbox;

    always @(posedge clk or posedge rst) begin : model
        bit old_full;
        bit full_now;
        if (rst) begin
            m_session = 0; m_full = 0; m_drain = 0; m_err = 0; m_match = 0;
            m_beat = 0; m_sbox = '0;
            for (int i = 0; i < NR; i++) m_written[i] = 0;
        end else if (start && !m_drain) begin
            m_slot[NR] = cipher_key;
            m_sbox     = sbox_in;
            for (int i = 0; i < NR; i++) m_written[i] = 0;
            m_session = 1; m_full = 0; m_err = 0; m_match = 0;
        end else begin
            old_full = m_full;
            if (wr_en) begin
                if (m_session && !old_full && int'(wr_idx) < NR) begin
                    m_slot[wr_idx]    = wr_key;
                    m_written[wr_idx] = 1;
                    full_now = 1;
                    for (int i = 0; i < NR; i++) if (!m_written[i]) full_now = 0;
                    m_full = full_now;
                end else begin
                    m_err = 1;
                end
            end
            if (dec_valid) m_match = (dec_data == ref_data);
            if (m_drain) begin
                if (rd_ready) begin
                    if (m_beat == NR) begin
                        m_drain = 0;
                        m_beat  = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end else if (rd_start && old_full) begin
                m_drain = 1;
                m_beat  = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [KW-1:0] model_key();
        return (m_beat < NR) ? m_slot[NR-1-m_beat] : m_slot[NR];
    endfunction

    function automatic logic [KW-1:0] plan_key(input int b);
        logic [7:0] v;
        v = 8'(NR - b);
        return (b < NR) ? {16{v}} : ck;
    endfunction

    task automatic check_all();
        check("m_rd_valid", KW'(rd_valid), KW'(m_drain));
        check("m_rd_idx", KW'(rd_idx), m_drain ? KW'(m_beat) : '0);
        check("m_rd_last", KW'(rd_last), KW'(m_drain && m_beat == NR));
        if (m_drain) check("m_rd_key", rd_key, model_key());
        check("m_keys_full", KW'(keys_full), KW'(m_full));
        check("m_wr_err", KW'(wr_err), KW'(m_err));
        check("m_sbox_out", KW'(sbox_out), KW'(m_sbox));
        check("m_data_match", KW'(data_match), KW'(m_match));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic fill();
        start = 1; cipher_key = ck; sbox_in = 8'h5A;
        step();
        start = 0;
        for (int i = 0; i < NR; i++) begin
            wr_en = 1; wr_idx = IW'(i); wr_key = {16{8'(i + 1)}};
            check("full_before_last", KW'(keys_full), '0);
            step();
        end
        wr_en = 0;
        check("full_after_fill", KW'(keys_full), KW'(1));
    endtask

    task automatic replay(input bit stall);
        int b;
        int k;
        rd_start = 1;
        step();
        rd_start = 0;
        b = 0;
        k = 0;
        while (b <= NR && k < 80) begin
            rd_ready = stall ? (k % 3 == 0) : 1'b1;
            check("rp_valid", KW'(rd_valid), KW'(1));
            check("rp_idx", KW'(rd_idx), KW'(b));
            check("rp_key", rd_key, plan_key(b));
            check("rp_last", KW'(rd_last), KW'(b == NR));
            if (rd_ready) b++;
            step();
            k++;
        end
        if (b <= NR) check("rp_timeout", KW'(b), KW'(NR + 1));
        rd_ready = 0;
        check("rp_done_valid", KW'(rd_valid), '0);
        check("rp_done_idx", KW'(rd_idx), '0);
    endtask

    initial begin
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        step();
        check("rst_valid", KW'(rd_valid), '0);
        check("rst_full", KW'(keys_full), '0);
        check("rst_err", KW'(wr_err), '0);

        // Fill and full replay
        fill();
        check("sbox_latched", KW'(sbox_out), KW'(8'h5A));
        check("no_err_fill", KW'(wr_err), '0);
        replay(0);
        replay(1);
        replay(0);

        // Illegal writes
        start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_idx = IW'(i); wr_key = {16{8'(i + 1)}}; step();
        end
        wr_idx = 4'd12; wr_key = '1; step();
        wr_en = 0;
        check("err_bad_idx", KW'(wr_err), KW'(1));
        check("err_full_hold", KW'(keys_full), '0);
        for (int i = 5; i < NR; i++) begin
            wr_en = 1; wr_idx = IW'(i); wr_key = {16{8'(i + 1)}}; step();
        end
        wr_idx = 4'd3; wr_key = '1; step();
        wr_en = 0;
        check("err_ready_wr", KW'(wr_err), KW'(1));
        check("err_ready_full", KW'(keys_full), KW'(1));
        replay(0);
        start = 1; step(); start = 0;
        check("err_cleared", KW'(wr_err), '0);

        // Reset mid-replay
        fill();
        rd_start = 1; step(); rd_start = 0; rd_ready = 1;
        repeat (5) step();
        check("beat5_idx", KW'(rd_idx), KW'(5));
        #2 rst = 1;
        #1;
        check("async_rst_valid", KW'(rd_valid), '0);
        check("async_rst_full", KW'(keys_full), '0);
        @(negedge clk);
        rst = 0; rd_ready = 0; rd_start = 1;
        step();
        rd_start = 0;
        check("rdstart_ignored", KW'(rd_valid), '0);
        step();

        // Match checker
        dec_valid = 1; dec_data = dead; ref_data = dead; step();
        dec_valid = 0;
        check("match_eq", KW'(data_match), KW'(1));
        step();
        check("match_hold", KW'(data_match), KW'(1));
        dec_valid = 1; dec_data = dead ^ 128'h1; step();
        dec_valid = 0;
        check("match_ne", KW'(data_match), '0);
        dec_valid = 1; dec_data = dead; step();
        dec_valid = 0; start = 1; step(); start = 0;
        check("match_start_clr", KW'(data_match), '0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 59) == 0);
            cipher_key = {$urandom, $urandom, $urandom, $urandom};
            sbox_in    = 8'($urandom);
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_idx     = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(10, 15)) : IW'($urandom_range(0, 9));
            wr_key     = {$urandom, $urandom, $urandom, $urandom};
            rd_start   = ($urandom_range(0, 5) == 0);
            rd_ready   = ($urandom_range(0, 9) < 7);
            dec_valid  = ($urandom_range(0, 4) == 0);
            ref_data   = {$urandom, $urandom, $urandom, $urandom};
            dec_data   = ($urandom_range(0, 1) == 1) ? ref_data : (ref_data ^ (KW'(1) << $urandom_range(0, KW - 1)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
